// File: rtl/vector_execute_sequencer.sv
// vector_execute_sequencer: multi-beat vector command issue with a 1-cycle read-to-writeback pipe and whole-command N/Z flags
module vector_execute_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_flags,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [2:0]        ExecuteOp,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  lane_neg,
  input  logic [LANES-1:0]  lane_zero,
  output logic              flag_n,
  output logic              flag_z,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [ADDR_W-1:0] src1, src2, dst, wa;
  logic [LEN_W-1:0] len, beat;
  logic flg, wv, acc_n, acc_z, accept;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (cmd_len != '0 ? ISSUE : DONE) : IDLE;
      ISSUE:   state_nx = (!stall && beat == len - LEN_W'(1)) ? DRAIN : ISSUE;
      DRAIN:   state_nx = stall ? DRAIN : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy      = state != IDLE;
    accept    = cmd_valid && cmd_ready;
    rd_en     = state == ISSUE && !stall;
    wr_en     = wv && !stall;
    done      = state == DONE;
    rd_addr1  = src1 + ADDR_W'(beat);
    rd_addr2  = src2 + ADDR_W'(beat);
    wr_addr   = wa;
    ExecuteOp = op;
  end
  // wv/wa form the write stage: the beat read this cycle is written back next cycle
  always_ff @(posedge clk)
    if (reset) begin
      op <= '0;
      src1 <= '0;
      src2 <= '0;
      dst <= '0;
      len <= '0;
      beat <= '0;
      wa <= '0;
      flg <= 1'b0;
      wv <= 1'b0;
      acc_n <= 1'b0;
      acc_z <= 1'b0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (accept) begin
        op <= cmd_op;
        src1 <= cmd_src1;
        src2 <= cmd_src2;
        dst <= cmd_dst;
        len <= cmd_len;
        beat <= '0;
        flg <= cmd_flags;
        wv <= 1'b0;
        if (cmd_flags) begin
          acc_n <= 1'b0;
          acc_z <= 1'b1;
        end
      end
      if (rd_en) begin
        beat <= beat + LEN_W'(1);
        wv <= 1'b1;
        wa <= dst + ADDR_W'(beat);
      end else if (state == DRAIN && !stall) wv <= 1'b0;
      if (wr_en && flg) begin
        acc_n <= acc_n | (|lane_neg);
        acc_z <= acc_z & (&lane_zero);
      end
      if (done && flg) begin
        flag_n <= acc_n;
        flag_z <= acc_z;
      end
    end
endmodule

// File: tb/tb_vector_execute_sequencer.sv
// tb_vector_execute_sequencer: directed checks of issue/writeback order, stall replay, flags, wrap and reset abort
module tb_vector_execute_sequencer;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, cmd_flags = 0, stall = 0;
  logic [2:0] cmd_op = 0, ExecuteOp;
  logic [7:0] cmd_src1 = 0, cmd_src2 = 0, cmd_dst = 0, cmd_len = 0;
  logic rd_en, wr_en, flag_n, flag_z, busy, done;
  logic [7:0] rd_addr1, rd_addr2, wr_addr;
  logic [3:0] lane_neg = 0, lane_zero = 0;
  logic [3:0] ln [0:7], lz [0:7];
  int n_chk = 0, n_fail = 0;

  vector_execute_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_flags(cmd_flags), .stall(stall), .rd_en(rd_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .ExecuteOp(ExecuteOp), .wr_en(wr_en),
    .wr_addr(wr_addr), .lane_neg(lane_neg), .lane_zero(lane_zero), .flag_n(flag_n),
    .flag_z(flag_z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [3:0] n0, n1, n2, n3, z0, z1, z2, z3);
    for (int i = 0; i < 8; i++) begin
      ln[i] = 0;
      lz[i] = 4'hF;
    end
    ln[0] = n0; ln[1] = n1; ln[2] = n2; ln[3] = n3;
    lz[0] = z0; lz[1] = z1; lz[2] = z2; lz[3] = z3;
  endtask

  // stall is held for cycles [st, st+sn) counted from the first cycle after accept
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] s1, s2, d, len,
                         input logic fl, input int st, input int sn);
    int cyc, nr, nw, exp_done;
    logic got_done;
    cmd_valid = 1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d;
    cmd_len = len; cmd_flags = fl;
    #1;
    chk("ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    cyc = 1; nr = 0; nw = 0; got_done = 0;
    exp_done = (len == 0) ? 1 : int'(len) + 2 + sn;
    while (!got_done && cyc < 40) begin
      stall = (cyc >= st && cyc < st + sn);
      lane_neg = nw < 8 ? ln[nw] : 4'h0;
      lane_zero = nw < 8 ? lz[nw] : 4'hF;
      #1;
      if (rd_en) begin
        chk("rd_addr1", rd_addr1, 8'(s1 + 8'(nr)));
        chk("rd_addr2", rd_addr2, 8'(s2 + 8'(nr)));
        nr++;
      end
      if (wr_en) begin
        chk("wr_addr", wr_addr, 8'(d + 8'(nw)));
        nw++;
      end
      if (stall) chk("stall_quiet", {rd_en, wr_en}, 0);
      chk("ready_low", cmd_ready, 0);
      chk("exec_op", ExecuteOp, op);
      if (done) begin
        got_done = 1;
        chk("done_cycle", cyc, exp_done);
      end
      tick();
      cyc++;
    end
    stall = 0;
    chk("done_seen", got_done, 1);
    chk("rd_count", nr, len);
    chk("wr_count", nw, len);
    chk("idle_after", {busy, cmd_ready, done}, 3'b010);
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {rd_en, wr_en, done}, 0);
    chk("rst_flags", {flag_n, flag_z}, 0);
    chk("rst_op", ExecuteOp, 0);
    // last beat clears Z
    set_lanes(0, 0, 0, 0, 4'hF, 4'hF, 4'hE, 4'hF);
    run_cmd(3, 8'h10, 8'h20, 8'h30, 3, 1, 99, 0);
    chk("t1_flag_n", flag_n, 0);
    chk("t1_flag_z", flag_z, 0);
    // one negative lane on one beat sets N; all-zero lanes keep Z
    set_lanes(0, 4'h1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
    run_cmd(3, 8'h10, 8'h20, 8'h30, 3, 1, 99, 0);
    chk("t2_flag_n", flag_n, 1);
    chk("t2_flag_z", flag_z, 1);
    // non-flag command must not disturb flags
    set_lanes(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    run_cmd(5, 8'h40, 8'h50, 8'h60, 2, 0, 99, 0);
    chk("t3_flag_n", flag_n, 1);
    chk("t3_flag_z", flag_z, 1);
    // address wrap
    run_cmd(1, 8'hFE, 8'hFF, 8'hFD, 4, 0, 99, 0);
    // stall for 2 cycles after beat 1 read
    set_lanes(0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
    run_cmd(2, 8'h00, 8'h80, 8'hC0, 3, 0, 3, 2);
    // empty flag command: N=0, Z=1
    run_cmd(6, 8'h11, 8'h22, 8'h33, 0, 1, 99, 0);
    chk("t6_flag_n", flag_n, 0);
    chk("t6_flag_z", flag_z, 1);
    // reset during beat 2 of a 5-beat command
    cmd_valid = 1; cmd_op = 7; cmd_src1 = 8'h01; cmd_src2 = 8'h02; cmd_dst = 8'h03;
    cmd_len = 5; cmd_flags = 1;
    tick();
    cmd_valid = 0;
    tick(); tick();
    chk("rst_mid_rd", rd_en, 1);
    chk("rst_mid_addr", rd_addr1, 8'h03);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_flags", {flag_n, flag_z}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_quiet", {rd_en, wr_en, done}, 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
